// File: rtl/dve_pkg.sv
// Shared definitions for the DVE run controller: FSM state encoding and
// default timing parameters.
package dve_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POR    = 3'd1,
        SETTLE = 3'd2,
        RUN    = 3'd3,
        STOP   = 3'd4
    } dve_state_t;

    localparam int DEF_RESET_CYCLES  = 16;
    localparam int DEF_SETTLE_CYCLES = 4;
    localparam int DEF_MAX_CYCLES    = 12000;
    localparam int DEF_CNT_W         = 32;

endpackage

// File: rtl/dve_delay_cnt.sv
// Loadable down-counter with a zero flag.
// The POR and SETTLE phases share one instance for their fixed-length timing.
module dve_delay_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    // Load takes priority over decrement; the counter parks at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/dve_run_ctrl.sv
// Run controller for a simulated core: sequences power-on reset, settle time,
// gated clock enable with pause, and ends a run on halt or cycle budget.
module dve_run_ctrl
    import dve_pkg::*;
#(
    parameter int RESET_CYCLES  = DEF_RESET_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int MAX_CYCLES    = DEF_MAX_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pause,
    input  logic             halt_req,
    output logic             core_por_n,
    output logic             core_clken,
    output logic [CNT_W-1:0] cycle_count,
    output logic [2:0]       state,
    output logic             done,
    output logic             timeout,
    output logic             finish_req
);

    localparam int DLY_MAX = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
    localparam int DLY_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;

    localparam logic [DLY_W-1:0] POR_LOAD    = DLY_W'(RESET_CYCLES - 1);
    localparam logic [DLY_W-1:0] SETTLE_LOAD = DLY_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_CYCLE  = CNT_W'(MAX_CYCLES - 1);

    dve_state_t       cur_state, nxt_state;
    logic             nxt_por_n, nxt_clken, nxt_done, nxt_timeout, nxt_finish;
    logic [CNT_W-1:0] nxt_count;
    logic             dly_load, dly_dec, dly_zero;
    logic [DLY_W-1:0] dly_val;

    dve_delay_cnt #(.W(DLY_W)) u_delay (
        .clk      (clk),
        .reset    (reset),
        .load     (dly_load),
        .load_val (dly_val),
        .dec      (dly_dec),
        .zero     (dly_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state   <= IDLE;
            core_por_n  <= 1'b0;
            core_clken  <= 1'b0;
            cycle_count <= '0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            finish_req  <= 1'b0;
        end else begin
            cur_state   <= nxt_state;
            core_por_n  <= nxt_por_n;
            core_clken  <= nxt_clken;
            cycle_count <= nxt_count;
            done        <= nxt_done;
            timeout     <= nxt_timeout;
            finish_req  <= nxt_finish;
        end
    end

    // Every output is computed one cycle ahead here and registered above.
    always_comb begin
        nxt_state   = cur_state;
        nxt_por_n   = core_por_n;
        nxt_clken   = 1'b0;
        nxt_count   = cycle_count;
        nxt_done    = 1'b0;
        nxt_timeout = timeout;
        nxt_finish  = finish_req;
        dly_load    = 1'b0;
        dly_val     = '0;
        dly_dec     = 1'b0;

        case (cur_state)
            IDLE, STOP: begin
                if (start) begin
                    nxt_state   = POR;
                    nxt_por_n   = 1'b0;
                    nxt_count   = '0;
                    nxt_timeout = 1'b0;
                    nxt_finish  = 1'b0;
                    dly_load    = 1'b1;
                    dly_val     = POR_LOAD;
                end
            end
            POR: begin
                if (dly_zero) begin
                    nxt_state = SETTLE;
                    nxt_por_n = 1'b1;
                    dly_load  = 1'b1;
                    dly_val   = SETTLE_LOAD;
                end else begin
                    dly_dec = 1'b1;
                end
            end
            SETTLE: begin
                if (dly_zero) begin
                    nxt_state = RUN;
                    nxt_clken = ~pause;
                end else begin
                    dly_dec = 1'b1;
                end
            end
            RUN: begin
                if (core_clken) begin
                    nxt_count = cycle_count + CNT_W'(1);
                end
                // Halt outranks budget exhaustion, so a simultaneous hit is not a timeout.
                if (halt_req) begin
                    nxt_state  = STOP;
                    nxt_done   = 1'b1;
                    nxt_finish = 1'b1;
                end else if (core_clken && (cycle_count == LAST_CYCLE)) begin
                    nxt_state   = STOP;
                    nxt_done    = 1'b1;
                    nxt_finish  = 1'b1;
                    nxt_timeout = 1'b1;
                end else begin
                    nxt_clken = ~pause;
                end
            end
            default: begin
                nxt_state = IDLE;
                nxt_por_n = 1'b0;
            end
        endcase
    end

    assign state = cur_state;

endmodule
